// File: rtl/decode_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer: 5 cycles per instruction plus memory wait cycles.
// Backpressure: stalls in WAIT_MEM until mem_valid; any fault parks the core in TRAP until rst.
module decode_ctrl #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [6:0]  alu_opcode,
  output logic [2:0]  alu_func3,
  output logic        alu_func7,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_result,
  output logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic [31:0] rd_wdata,
  output logic [31:0] pc,
  output logic        illegal
);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] WAIT_MEM  = 3'd1;
  localparam logic [2:0] DECODE    = 3'd2;
  localparam logic [2:0] EXECUTE   = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] TRAP      = 3'd5;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic [2:0]  state;
  logic [31:0] ir;
  logic [31:0] rs1_q, rs2_q, res_q;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_b, imm_j;
  logic        is_r, is_i, is_b, is_jalr, is_jal, is_lui, is_shift;
  logic        decode_ok, br_taken, misalign;
  logic [31:0] next_pc, wb_data;

  assign opc   = ir[6:0];
  assign f3    = ir[14:12];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign is_r     = (opc == OP_RTYPE);
  assign is_i     = (opc == OP_ITYPE);
  assign is_b     = (opc == OP_BTYPE);
  assign is_jalr  = (opc == OP_JALR);
  assign is_jal   = (opc == OP_JAL);
  assign is_lui   = (opc == OP_LUI);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // func3 010/011 have no branch meaning and are treated as undefined
  assign decode_ok = is_r | is_i | is_jal | is_jalr | is_lui | (is_b & (f3[2:1] != 2'b01));

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (rs1_q == rs2_q);
      3'b001:  br_taken = (rs1_q != rs2_q);
      3'b100:  br_taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  br_taken = (rs1_q <  rs2_q);
      3'b111:  br_taken = (rs1_q >= rs2_q);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc + 32'd4;
    if (is_b && br_taken)
      next_pc = pc + imm_b;
    else if (is_jal)
      next_pc = pc + imm_j;
    else if (is_jalr)
      next_pc = (rs1_q + imm_i) & ~32'd1;
  end

  always_comb begin
    wb_data = res_q;
    if (is_jal || is_jalr)
      wb_data = pc + 32'd4;
    else if (is_lui)
      wb_data = {ir[31:12], 12'd0};
  end

  assign misalign = TRAP_ON_MISALIGN & next_pc[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      illegal <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        FETCH: state <= WAIT_MEM;
        WAIT_MEM: begin
          if (mem_valid) begin
            ir    <= mem_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          rs1_q <= rs1_data;
          rs2_q <= rs2_data;
          if (decode_ok) begin
            state <= EXECUTE;
          end else begin
            state   <= TRAP;
            illegal <= 1'b1;
          end
        end
        EXECUTE: begin
          res_q <= alu_result;
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          // a misaligned target leaves pc on the faulting instruction
          if (misalign) begin
            state   <= TRAP;
            illegal <= 1'b1;
          end else begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        TRAP: illegal <= 1'b1;
        default: begin
          state   <= TRAP;
          illegal <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req  = (state == FETCH) & ~rst;
  assign mem_addr = pc;
  assign rs1_addr = ir[19:15];
  assign rs2_addr = ir[24:20];
  assign rd_addr  = ir[11:7];
  assign rd_wdata = wb_data;
  assign rd_we    = (state == WRITEBACK) & ~rst & ~is_b & (ir[11:7] != 5'd0) & ~misalign;

  always_comb begin
    alu_opcode = '0;
    alu_func3  = '0;
    alu_func7  = 1'b0;
    alu_op1    = '0;
    alu_op2    = '0;
    if (state == EXECUTE) begin
      alu_opcode = opc;
      alu_func3  = f3;
      alu_func7  = (is_r || (is_i && is_shift)) ? ir[30] : 1'b0;
      if (is_r || is_i)
        alu_op1 = rs1_q;
      if (is_r)
        alu_op2 = rs2_q;
      else if (is_i)
        alu_op2 = is_shift ? {27'd0, ir[24:20]} : imm_i;
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: directed cases then random instructions against an instruction-level model
// holding the architectural pc and register file.
module tb_decode_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_valid;
  logic [31:0] mem_addr, mem_rdata;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_func3;
  logic        alu_func7;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic        rd_we;
  logic [31:0] rd_wdata, pc;
  logic        illegal;

  logic [31:0] regs [32];
  logic [31:0] m_pc;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  decode_ctrl #(.RESET_PC(RESET_PC), .TRAP_ON_MISALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func7(alu_func7),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
    .rd_addr(rd_addr), .rd_we(rd_we), .rd_wdata(rd_wdata), .pc(pc), .illegal(illegal)
  );

  function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign rs1_data   = regs[rs1_addr];
  assign rs2_data   = regs[rs2_addr];
  assign alu_result = alu_f(alu_func3, alu_func7, alu_op1, alu_op2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [12:0] im);
    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] im);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] s1,
                                        input logic [11:0] im);
    return {im, s1, f3, rd, op};
  endfunction

  function automatic bit supported(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 || op == 7'b1100011 ||
           op == 7'b1100111 || op == 7'b1101111 || op == 7'b0110111;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, s1, s2;
    logic [2:0]  f3;
    logic [11:0] ii;
    logic [6:0]  op;
    int          k;
    rd = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom); f3 = 3'($urandom);
    k  = $urandom_range(0, 19);
    if (k < 5)
      return {(($urandom_range(0, 1) == 1) && (f3 == 3'd0 || f3 == 3'd5)) ? 7'b0100000 : 7'b0,
              s2, s1, f3, rd, 7'b0110011};
    if (k < 10) begin
      if (f3 == 3'd1)      ii = {7'b0, 5'($urandom)};
      else if (f3 == 3'd5) ii = {($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0, 5'($urandom)};
      else                 ii = 12'($urandom);
      return enc_i(7'b0010011, f3, rd, s1, ii);
    end
    if (k < 13) begin
      if (f3[2:1] == 2'b01) f3[2] = 1'b1;
      return enc_b(f3, s1, s2, 13'(4 * $urandom_range(0, 32) - 64));
    end
    if (k == 13) return enc_j(rd, 21'(4 * $urandom_range(0, 64) - 128));
    if (k == 14) begin
      ii = 12'($urandom);
      if (((regs[s1] + {{20{ii[11]}}, ii}) & 32'd2) != 0 && $urandom_range(0, 7) != 0)
        ii = ii ^ 12'd2;
      return enc_i(7'b1100111, 3'b000, rd, s1, ii);
    end
    if (k < 17) return {20'($urandom), rd, 7'b0110111};
    if (k == 17) return enc_b({2'b01, 1'($urandom)}, s1, s2, 13'd8);
    if (k == 18) begin
      op = 7'($urandom);
      while (supported(op)) op = 7'($urandom);
      return {25'($urandom), op};
    end
    return 32'h0000_0013;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, mem_req}, 32'd1);
  endtask

  // Caller raises rst just after a rising edge.
  task automatic reset_seq();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, rd_we}, 32'd0);
    chk("rst_ill", {31'd0, illegal}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_req", {31'd0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, RESET_PC);
    m_pc = RESET_PC;
  endtask

  task automatic trap_window();
    int reqs = 0;
    repeat (20) begin
      if (mem_req === 1'b1) reqs++;
      @(negedge clk);
    end
    chk("trap_noreq", reqs, 0);
    chk("trap_ill", {31'd0, illegal}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = $urandom;
    reset_seq();
  endtask

  task automatic do_instr(input logic [31:0] ins, input int gap);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a, b, i_imm, b_imm, j_imm, e_op2, e_wd, npc;
    logic        legal, is_r, is_i, sh, alt, tk, we;
    op = ins[6:0]; f3 = ins[14:12]; rd = ins[11:7];
    a = regs[ins[19:15]]; b = regs[ins[24:20]];
    i_imm = {{20{ins[31]}}, ins[31:20]};
    b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    legal = supported(op) && !(op == 7'b1100011 && (f3 == 3'd2 || f3 == 3'd3));
    is_r  = (op == 7'b0110011);
    is_i  = (op == 7'b0010011);
    sh    = is_i && (f3 == 3'd1 || f3 == 3'd5);
    alt   = (is_r || sh) ? ins[30] : 1'b0;
    e_op2 = is_r ? b : (sh ? {27'd0, ins[24:20]} : i_imm);
    case (f3)
      3'd0:    tk = (a == b);
      3'd1:    tk = (a != b);
      3'd4:    tk = ($signed(a) <  $signed(b));
      3'd5:    tk = ($signed(a) >= $signed(b));
      3'd6:    tk = (a <  b);
      default: tk = (a >= b);
    endcase
    if (op == 7'b1100011 && tk) npc = m_pc + b_imm;
    else if (op == 7'b1101111)  npc = m_pc + j_imm;
    else if (op == 7'b1100111)  npc = (a + i_imm) & ~32'd1;
    else                        npc = m_pc + 32'd4;
    if (is_r || is_i)          e_wd = alu_f(f3, alt, a, e_op2);
    else if (op == 7'b0110111) e_wd = {ins[31:12], 12'd0};
    else                       e_wd = m_pc + 32'd4;
    we = legal && !npc[1] && op != 7'b1100011 && rd != 5'd0;

    wait_req();
    chk("fetch_addr", mem_addr, m_pc);
    @(posedge clk);
    #1;
    repeat (gap) begin
      mem_valid = 1'b0;
      mem_rdata = $urandom;
      @(posedge clk);
      #1;
    end
    mem_valid = 1'b1;
    mem_rdata = ins;
    @(posedge clk);
    #1;
    mem_valid = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    chk("dec_idle", {19'd0, mem_req, rd_we, alu_func7, alu_func3, alu_opcode}, 32'd0);
    chk("dec_ops", alu_op1 | alu_op2, 32'd0);
    @(negedge clk);
    if (!legal) begin
      trap_window();
      return;
    end
    chk("ex_opcode", {25'd0, alu_opcode}, {25'd0, op});
    chk("ex_func3", {29'd0, alu_func3}, {29'd0, f3});
    chk("ex_func7", {31'd0, alu_func7}, {31'd0, alt});
    if (is_r || is_i) begin
      chk("ex_op1", alu_op1, a);
      chk("ex_op2", alu_op2, e_op2);
    end
    @(negedge clk);
    chk("wb_we", {31'd0, rd_we}, {31'd0, we});
    if (we) begin
      chk("wb_rd", {27'd0, rd_addr}, {27'd0, rd});
      chk("wb_data", rd_wdata, e_wd);
      regs[rd] = e_wd;
    end
    @(negedge clk);
    if (npc[1]) begin
      chk("mis_pc", pc, m_pc);
      trap_window();
      return;
    end
    chk("next_req", {31'd0, mem_req}, 32'd1);
    chk("next_pc", pc, npc);
    m_pc = npc;
  endtask

  initial begin
    regs[0] = 32'd0;
    for (int i = 1; i < 32; i++) regs[i] = (i < 12) ? $urandom_range(0, 3) : $urandom;
    m_pc      = RESET_PC;
    rst       = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 32'h0070_0293;
    @(posedge clk);
    #1;
    reset_seq();

    do_instr(32'h0050_0093, 0);                     // addi x1,x0,5
    regs[1] = 32'd7;
    regs[2] = 32'd9;
    do_instr(32'h4020_81B3, 0);                     // sub x3,x1,x2
    do_instr(32'h0000_0013, 1);
    do_instr(32'h0000_0013, 2);
    do_instr(enc_b(3'b000, 5'd0, 5'd0, 13'h1FF0), 0);  // beq x0,x0,-16 at 0x10
    for (int i = 0; i < 4; i++) do_instr(32'h0000_0013, i);
    regs[5] = 32'hFFFF_FFFF;
    regs[6] = 32'd1;
    do_instr(enc_b(3'b110, 5'd5, 5'd6, 13'd8), 0);     // bltu not taken
    regs[2] = 32'h0000_0101;
    do_instr(enc_i(7'b1100111, 3'b000, 5'd1, 5'd2, 12'd4), 0);  // jalr x1,4(x2)
    do_instr(enc_j(5'd7, 21'd2), 0);                   // misaligned jal target
    do_instr(32'h0000_007F, 3);                        // undefined opcode

    // reset hits WAIT_MEM while mem_valid is already high
    wait_req();
    @(posedge clk);
    #1 rst = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 32'h0070_0293;
    reset_seq();
    do_instr(32'h00A0_0293, 0);

    for (int n = 0; n < 200; n++) do_instr(rand_instr(), $urandom_range(0, 3));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_ON_MISALIGN, default 1, meaning a branch/jump target with bit 1 set enters TRAP.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- mem_req  out  1  instruction fetch request, one-cycle pulse
- mem_addr  out  32  fetch address, equal to pc
- mem_valid  in  1  fetch data valid
- mem_rdata  in  32  fetched instruction
- rs1_addr, rs2_addr  out  5  register-file read addresses, instr[19:15] and instr[24:20]
- rs1_data, rs2_data  in  32  register-file read data, combinational from the addresses
- alu_opcode  out  7  ALU opcode field
- alu_func3  out  3  ALU func3 field
- alu_func7  out  1  ALU func7 bit (instr[30])
- alu_op1, alu_op2  out  32  ALU operands
- alu_result  in  32  ALU result, combinational
- rd_addr  out  5  writeback register
- rd_we  out  1  writeback enable, one-cycle pulse
- rd_wdata  out  32  writeback data
- pc  out  32  current program counter
- illegal  out  1  sticky trap flag

Function
REQ-005 SHALL implement a state machine with states FETCH, WAIT_MEM, DECODE, EXECUTE, WRITEBACK and TRAP.
REQ-006 FETCH SHALL assert mem_req for exactly one cycle with mem_addr=pc, then go to WAIT_MEM.
REQ-007 WAIT_MEM SHALL hold until mem_valid=1, latch mem_rdata into IR, then go to DECODE; mem_valid outside WAIT_MEM SHALL be ignored.
REQ-008 DECODE SHALL drive rs1_addr/rs2_addr from IR and latch rs1_data/rs2_data at the clock edge.
REQ-008 (cont.) DECODE SHALL go to TRAP on an unsupported opcode, or on BTYPE func3 010/011; otherwise it SHALL go to EXECUTE.
REQ-009 Supported opcodes SHALL be RTYPE 0110011, ITYPE 0010011, BTYPE 1100011, JALR 1100111, JAL 1101111 and LUI 0110111.
REQ-010 EXECUTE SHALL drive alu_opcode=IR[6:0] and alu_func3=IR[14:12], latch alu_result, and go to WRITEBACK.
REQ-011 alu_func7 SHALL be IR[30] for RTYPE and for ITYPE func3 001/101, and 0 otherwise.
REQ-012 alu_op1 SHALL be rs1 for RTYPE/ITYPE. alu_op2 SHALL be:
- rs2 for RTYPE
- sign-extended immI for ITYPE, except zero-extended IR[24:20] for shifts.
REQ-013 Outside EXECUTE, all alu_* outputs SHALL be 0.
REQ-014 Branch compare SHALL be computed internally on latched rs1/rs2:
- beq/bne: equality
- blt/bge: signed compare
- bltu/bgeu: unsigned compare
REQ-015 WRITEBACK SHALL pulse rd_we for one cycle, except for BTYPE or rd_addr=0, where rd_we stays 0. rd_wdata SHALL be:
- alu_result for RTYPE/ITYPE
- pc+4 for JAL/JALR
- {immU,12'b0} for LUI
REQ-016 WRITEBACK SHALL update pc as follows, all additions mod 2^32, then go to FETCH:
- taken branch: pc+immB
- JAL: pc+immJ
- JALR: (rs1+immI)&~1
- otherwise: pc+4
REQ-017 If TRAP_ON_MISALIGN=1 and the new pc[1]=1, WRITEBACK SHALL go to TRAP, suppress rd_we, and leave pc unchanged.
REQ-018 TRAP SHALL set illegal=1, issue no further mem_req, and exit only on rst.
REQ-019 Instruction latency SHALL be 5 cycles, plus N when mem_valid arrives N cycles after WAIT_MEM entry.

Reset
REQ-020 rst=1 at any clock edge SHALL force FETCH with pc=RESET_PC, IR=0, illegal=0, and mem_req=rd_we=0, including mid-WAIT_MEM or in TRAP.
REQ-021 The first mem_req SHALL occur in the first cycle after rst deasserts.
REQ-022 A mem_valid pending from before reset SHALL be ignored.

Verification
REQ-023 addi x1,x0,5 (0x00500093), mem_valid on the first WAIT_MEM cycle:
- EXECUTE alu_opcode=0010011, op1=0, op2=5
- rd_we=1, rd_addr=1, rd_wdata=5 (ALU model)
- pc 0->4, 5 cycles total
REQ-024 sub x3,x1,x2 with x1=7, x2=9 -> alu_func7=1, rd_wdata=0xFFFFFFFE.
REQ-025 Branch pair at pc=0x10:
- beq, rs1=rs2, immB=-16 -> pc=0x0, no rd_we
- bltu, rs1=0xFFFFFFFF, rs2=1 -> not taken, pc=0x14
REQ-026 jalr x1,4(x2) with x2=0x101 -> rd_wdata=pc+4, pc=0x104.
REQ-027 Opcode 0x0000007F -> illegal=1 and no mem_req for 20 cycles; rst pulse -> illegal=0, mem_addr=RESET_PC.
REQ-028 rst asserted during WAIT_MEM with mem_valid held high -> after reset, one fresh mem_req is issued before IR loads.
